// File: rtl/ctrl_unit_pipe.sv
// Registered control decoder with valid/ready input and output stages.
// Latency: 1 cycle for ordinary ops, MUL_CYCLES/DIV_CYCLES cycles for M-ext ops.
// Backpressure: in_ready drops while an M-op is in flight or the output register is held.
module ctrl_unit_pipe #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 34,
  parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  type_in,
  input  logic [2:0]  funct3_in,
  input  logic        funct7_b5_in,
  input  logic        funct7_b0_in,
  input  logic        flush_in,
  output logic        ctrl_valid,
  input  logic        ctrl_ready,
  output logic [17:0] ctrl_out,
  output logic        mdu_start,
  output logic [2:0]  mdu_op,
  output logic        mdu_kill
);

  typedef enum logic {IDLE = 1'b0, MDU_BUSY = 1'b1} state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLL = 4'b0101,
                         ALU_SRL = 4'b0110, ALU_SLT = 4'b0111, ALU_SLTU = 4'b1000,
                         ALU_SRA = 4'b1001, ALU_PASSB = 4'b1111;

  state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [17:0]   out_q, out_d;
  logic [17:0]   word_q, word_d;
  logic [2:0]    op_q, op_d;
  logic          start_q, start_d;
  logic          kill_q, kill_d;

  logic [17:0]   dec_word;
  logic          dec_is_m;
  logic [3:0]    alu_f3;
  logic          onehot;
  logic          out_free;
  logic          accept;
  logic          mdu_done;

  // Decode type/funct into the 18-bit control word; illegal words collapse to the flag alone.
  always_comb begin
    dec_word = '0;
    dec_is_m = 1'b0;
    onehot   = (type_in != 9'd0) && ((type_in & (type_in - 9'd1)) == 9'd0);
    case (funct3_in)
      3'b000:  alu_f3 = ALU_ADD;
      3'b001:  alu_f3 = ALU_SLL;
      3'b010:  alu_f3 = ALU_SLT;
      3'b011:  alu_f3 = ALU_SLTU;
      3'b100:  alu_f3 = ALU_XOR;
      3'b101:  alu_f3 = funct7_b5_in ? ALU_SRA : ALU_SRL;
      3'b110:  alu_f3 = ALU_OR;
      default: alu_f3 = ALU_AND;
    endcase
    if (!onehot) begin
      dec_word = 18'h20000;
    end else if (type_in[0]) begin          // LUI
      dec_word = {1'b0, 1'b1, 2'b00, 3'b100, 1'b0, 1'b1, 2'b00, ALU_PASSB, 2'b00, 1'b0};
    end else if (type_in[1]) begin          // AUIPC
      dec_word = {1'b0, 1'b1, 2'b00, 3'b100, 1'b1, 1'b1, 2'b00, ALU_ADD, 2'b00, 1'b0};
    end else if (type_in[2]) begin          // JAL
      dec_word = {1'b0, 1'b1, 2'b00, 3'b101, 1'b0, 1'b0, 2'b10, ALU_ADD, 2'b10, 1'b0};
    end else if (type_in[3]) begin          // JALR
      if (funct3_in != 3'b000) dec_word = 18'h20000;
      else dec_word = {1'b0, 1'b1, 2'b00, 3'b001, 1'b0, 1'b1, 2'b10, ALU_ADD, 2'b11, 1'b0};
    end else if (type_in[4]) begin          // BRANCH
      if (funct3_in == 3'b010 || funct3_in == 3'b011) dec_word = 18'h20000;
      else dec_word = {1'b0, 1'b0, 2'b00, 3'b011, 1'b0, 1'b0, 2'b00, ALU_SUB, 2'b01, 1'b0};
    end else if (type_in[5]) begin          // STORE
      if (funct3_in >= 3'b011) dec_word = 18'h20000;
      else dec_word = {1'b0, 1'b0, 2'b01, 3'b010, 1'b0, 1'b1, 2'b00, ALU_ADD, 2'b00, 1'b0};
    end else if (type_in[6]) begin          // LOAD
      if (funct3_in == 3'b011 || funct3_in[2:1] == 2'b11) dec_word = 18'h20000;
      else dec_word = {1'b0, 1'b1, 2'b10, 3'b001, 1'b0, 1'b1, 2'b01, ALU_ADD, 2'b00, 1'b0};
    end else if (type_in[7]) begin          // I-ALU: immediate forms never subtract
      dec_word = {1'b0, 1'b1, 2'b00, 3'b001, 1'b0, 1'b1, 2'b00, alu_f3, 2'b00, 1'b0};
    end else if (funct7_b0_in) begin        // R-type M-extension
      dec_is_m = 1'b1;
      dec_word = {1'b0, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 2'b11, ALU_ADD, 2'b00, 1'b1};
    end else begin                          // R-type integer
      dec_word = {1'b0, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 2'b00,
                  (funct3_in == 3'b000 && funct7_b5_in) ? ALU_SUB : alu_f3, 2'b00, 1'b0};
    end
  end

  assign out_free = !valid_q | ctrl_ready;
  assign in_ready = (state_q == IDLE) & out_free & !flush_in & !rst;
  assign accept   = in_valid & in_ready;
  // The final decrement and the output load share one edge so valid rises N cycles after accept.
  assign mdu_done = (state_q == MDU_BUSY) && (cnt_q <= CNT_W'(1)) && out_free;

  // Next-state: flush wins, otherwise drain/load the output register and sequence M-ops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    out_d   = out_q;
    word_d  = word_q;
    op_d    = op_q;
    start_d = 1'b0;
    kill_d  = 1'b0;
    if (flush_in) begin
      valid_d = 1'b0;
      state_d = IDLE;
      cnt_d   = '0;
      kill_d  = (state_q == MDU_BUSY);
    end else begin
      if (valid_q && ctrl_ready) valid_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (dec_is_m) begin
              state_d = MDU_BUSY;
              cnt_d   = funct3_in[2] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
              word_d  = dec_word;
              op_d    = funct3_in;
              start_d = 1'b1;
            end else begin
              out_d   = dec_word;
              valid_d = 1'b1;
            end
          end
        end
        default: begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          if (mdu_done) begin
            out_d   = word_q;
            valid_d = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  // State register with synchronous reset; reset drops any in-flight op silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      word_q  <= '0;
      op_q    <= '0;
      start_q <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      word_q  <= word_d;
      op_q    <= op_d;
      start_q <= start_d;
      kill_q  <= kill_d;
    end
  end

  assign ctrl_valid = valid_q;
  assign ctrl_out   = out_q;
  assign mdu_start  = start_q;
  assign mdu_op     = op_q;
  assign mdu_kill   = kill_q;

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
module tb_ctrl_unit_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  type_in = '0;
  logic [2:0]  funct3_in = '0;
  logic        funct7_b5_in = 1'b0;
  logic        funct7_b0_in = 1'b0;
  logic        flush_in = 1'b0;
  logic        ctrl_valid;
  logic        ctrl_ready = 1'b1;
  logic [17:0] ctrl_out;
  logic        mdu_start;
  logic [2:0]  mdu_op;
  logic        mdu_kill;

  int checks = 0;
  int failures = 0;

  ctrl_unit_pipe #(.MUL_CYCLES(3), .DIV_CYCLES(34)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .type_in(type_in), .funct3_in(funct3_in), .funct7_b5_in(funct7_b5_in),
    .funct7_b0_in(funct7_b0_in), .flush_in(flush_in), .ctrl_valid(ctrl_valid),
    .ctrl_ready(ctrl_ready), .ctrl_out(ctrl_out), .mdu_start(mdu_start),
    .mdu_op(mdu_op), .mdu_kill(mdu_kill)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [8:0] t, input logic [2:0] f3,
                       input logic b5, input logic b0);
    in_valid = v; type_in = t; funct3_in = f3; funct7_b5_in = b5; funct7_b0_in = b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (ctrl_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ctrl_valid); end
    checks++; if (ctrl_out !== 18'h0) begin failures++; $display("FAIL reset_out got=%h exp=00000", ctrl_out); end
    checks++; if ({mdu_start, mdu_op, mdu_kill} !== 5'b0) begin failures++; $display("FAIL reset_mdu got=%b%b%b exp=0", mdu_start, mdu_op, mdu_kill); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    ctrl_ready = 1'b1;
    drive(1'b1, 9'h100, 3'b000, 1'b0, 1'b0);
    tick();
    checks++; if (ctrl_valid !== 1'b1 || ctrl_out !== 18'h10000) begin failures++; $display("FAIL r_add got=%b/%h exp=1/10000", ctrl_valid, ctrl_out); end
    drive(1'b1, 9'h100, 3'b000, 1'b1, 1'b0); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if (ctrl_valid !== 1'b1 || ctrl_out !== 18'h10008) begin failures++; $display("FAIL r_sub got=%b/%h exp=1/10008", ctrl_valid, ctrl_out); end
    drive(1'b0, 9'h0, 3'b000, 1'b0, 1'b0);
    tick();
    checks++; if (ctrl_valid !== 1'b0) begin failures++; $display("FAIL drain got=%b exp=0", ctrl_valid); end
  endtask

  task automatic test_stall();
    ctrl_ready = 1'b0;
    drive(1'b1, 9'h001, 3'b000, 1'b0, 1'b0);
    tick();
    drive(1'b0, 9'h0, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (ctrl_valid !== 1'b1 || ctrl_out !== 18'h12278 || in_ready !== 1'b0) begin
        failures++; $display("FAIL lui_hold[%0d] got=%b/%h rdy=%b exp=1/12278 rdy=0", i, ctrl_valid, ctrl_out, in_ready);
      end
      if (i < 2) tick();
    end
    ctrl_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lui_release_rdy got=%b exp=1", in_ready); end
    tick();
    checks++; if (ctrl_valid !== 1'b0) begin failures++; $display("FAIL lui_drain got=%b exp=0", ctrl_valid); end
  endtask

  task automatic run_mop(input logic [2:0] f3, input int n, input logic hold);
    int k;
    int rdy_bad;
    int start_bad;
    int rise;
    ctrl_ready = 1'b1;
    drive(1'b1, 9'h100, f3, 1'b0, 1'b1); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mop%0d_accept got=%b exp=1", n, in_ready); end
    tick();
    drive(1'b0, 9'h0, 3'b000, 1'b0, 1'b0);
    if (hold) ctrl_ready = 1'b0;
    checks++; if (mdu_start !== 1'b1 || mdu_op !== f3) begin failures++; $display("FAIL mop%0d_start got=%b/%b exp=1/%b", n, mdu_start, mdu_op, f3); end
    k = 1; rdy_bad = 0; start_bad = 0;
    while (ctrl_valid !== 1'b1 && k < 100) begin
      if (in_ready !== 1'b0) rdy_bad++;
      tick(); k++;
      if (mdu_start !== 1'b0) start_bad++;
    end
    rise = (ctrl_valid === 1'b1) ? k : 0;
    checks++; if (rise != n) begin failures++; $display("FAIL mop%0d_latency got=%0d exp=%0d", n, rise, n); end
    checks++; if (rdy_bad != 0 || start_bad != 0) begin failures++; $display("FAIL mop%0d_busy rdy_hi=%0d start_hi=%0d exp=0/0", n, rdy_bad, start_bad); end
    checks++; if (ctrl_out !== 18'h10181) begin failures++; $display("FAIL mop%0d_word got=%h exp=10181", n, ctrl_out); end
    if (hold) begin
      tick(); tick();
      checks++; if (ctrl_valid !== 1'b1 || ctrl_out !== 18'h10181 || in_ready !== 1'b0) begin
        failures++; $display("FAIL mop%0d_held got=%b/%h rdy=%b exp=1/10181 rdy=0", n, ctrl_valid, ctrl_out, in_ready);
      end
      ctrl_ready = 1'b1;
    end
    tick();
    checks++; if (ctrl_valid !== 1'b0) begin failures++; $display("FAIL mop%0d_drain got=%b exp=0", n, ctrl_valid); end
  endtask

  task automatic test_decode();
    logic [8:0]  tv [13];
    logic [2:0]  fv [13];
    logic        bv [13];
    logic [17:0] ev [13];
    tv = '{9'h003, 9'h040, 9'h008, 9'h000, 9'h010, 9'h020, 9'h040, 9'h004,
           9'h080, 9'h080, 9'h002, 9'h008, 9'h020};
    fv = '{3'b000, 3'b111, 3'b001, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000,
           3'b101, 3'b000, 3'b000, 3'b000, 3'b011};
    bv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ev = '{18'h20000, 18'h20000, 18'h20000, 18'h20000, 18'h0180A, 18'h05200, 18'h18A80,
           18'h12904, 18'h10A48, 18'h10A00, 18'h12600, 18'h10B06, 18'h20000};
    ctrl_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, tv[i], fv[i], bv[i], 1'b0);
      tick();
      checks++; if (ctrl_valid !== 1'b1 || ctrl_out !== ev[i]) begin
        failures++; $display("FAIL decode[%0d] type=%h f3=%b got=%b/%h exp=1/%h", i, tv[i], fv[i], ctrl_valid, ctrl_out, ev[i]);
      end
    end
    drive(1'b0, 9'h0, 3'b000, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_flush();
    int late;
    ctrl_ready = 1'b1;
    drive(1'b1, 9'h100, 3'b100, 1'b0, 1'b1);
    tick();
    drive(1'b0, 9'h0, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    flush_in = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick();
    flush_in = 1'b0;
    checks++; if (mdu_kill !== 1'b1 || ctrl_valid !== 1'b0) begin failures++; $display("FAIL flush_kill got=%b/%b exp=1/0", mdu_kill, ctrl_valid); end
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_idle_rdy got=%b exp=1", in_ready); end
    tick();
    checks++; if (mdu_kill !== 1'b0) begin failures++; $display("FAIL flush_kill_pulse got=%b exp=0", mdu_kill); end
    late = 0;
    for (int i = 0; i < 40; i++) begin
      if (ctrl_valid !== 1'b0) late++;
      tick();
    end
    checks++; if (late != 0) begin failures++; $display("FAIL flush_no_result got=%0d exp=0", late); end
    ctrl_ready = 1'b0;
    drive(1'b1, 9'h001, 3'b000, 1'b0, 1'b0);
    tick();
    drive(1'b0, 9'h0, 3'b000, 1'b0, 1'b0);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    checks++; if (ctrl_valid !== 1'b0 || mdu_kill !== 1'b0) begin failures++; $display("FAIL flush_outreg got=%b/%b exp=0/0", ctrl_valid, mdu_kill); end
    ctrl_ready = 1'b1;
  endtask

  task automatic test_rst_mid();
    int late;
    ctrl_ready = 1'b1;
    drive(1'b1, 9'h100, 3'b101, 1'b0, 1'b1);
    tick();
    drive(1'b0, 9'h0, 3'b000, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_rdy got=%b exp=0", in_ready); end
    tick();
    checks++; if ({ctrl_valid, ctrl_out, mdu_start, mdu_op, mdu_kill} !== 24'h0) begin
      failures++; $display("FAIL rst_mid_outs got=%b/%h/%b/%b/%b exp=all 0", ctrl_valid, ctrl_out, mdu_start, mdu_op, mdu_kill);
    end
    rst = 1'b0;
    late = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ctrl_valid !== 1'b0 || mdu_kill !== 1'b0) late++;
    end
    checks++; if (late != 0) begin failures++; $display("FAIL rst_mid_quiet got=%0d exp=0", late); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    run_mop(3'b100, 34, 1'b0);
    run_mop(3'b000, 3, 1'b0);
    run_mop(3'b001, 3, 1'b1);
    test_decode();
    test_flush();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
